// File: rtl/nibble_serial_addsub_if.sv
// Operand/result bundle for the nibble-serial add/sub unit.
// The requester drives the master side; the arithmetic unit implements the slave side.
interface nibble_serial_addsub_if #(
    parameter int NIBBLES = 4
);
    localparam int DATA_W = 4 * NIBBLES;

    logic              start;
    logic              sub;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              carry_out;
    logic              overflow;
    logic              zero;
    logic              negative;

    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, result, carry_out, overflow, zero, negative
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, result, carry_out, overflow, zero, negative
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-precision add/subtract, one 4-bit slice per clock, LSB nibble first.
// Optional macro SATURATE_EN clamps an overflowing result to the signed limit.
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_serial_addsub_if.slave  bus
);
    localparam int DATA_W = 4 * NIBBLES;
    localparam int CNT_W  = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic              sub_reg;
    logic              carry_reg;
    logic              msb_carry_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              done_reg;
    logic [DATA_W-1:0] result_reg;
    logic              carry_out_reg;
    logic              overflow_reg;
    logic              zero_reg;
    logic              negative_reg;

    logic              accept;
    logic              last_nib;

    // 4-bit add/sub slice; split at bit 3 so the carry into the MSB is visible
    logic [3:0] a_nib, b_nib, sum_nib;
    logic [3:0] low_sum;
    logic [1:0] high_sum;
    logic       slice_cout, slice_c3;

    assign a_nib    = a_reg[{cnt_reg, 2'b00} +: 4];
    assign b_nib    = b_reg[{cnt_reg, 2'b00} +: 4] ^ {4{sub_reg}};
    assign low_sum  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_reg};
    assign high_sum = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, low_sum[3]};
    assign sum_nib    = {high_sum[0], low_sum[2:0]};
    assign slice_cout = high_sum[1];
    assign slice_c3   = low_sum[3];

    assign last_nib = (cnt_reg == LAST_CNT);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            msb_carry_reg <= 1'b0;
            cnt_reg       <= '0;
        end else if (accept) begin
            a_reg     <= bus.op_a;
            b_reg     <= bus.op_b;
            sub_reg   <= bus.sub;
            carry_reg <= bus.sub;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            carry_reg <= slice_cout;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (last_nib) begin
                msb_carry_reg <= slice_c3;
            end
        end
    end

    // Partial-sum nibbles, each loaded only on its own RUN cycle
    logic [DATA_W-1:0] partial_flat;

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            logic [3:0] nib_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    nib_reg <= 4'h0;
                end else if ((state_reg == RUN) && (cnt_reg == CNT_W'(gi))) begin
                    nib_reg <= sum_nib;
                end
            end
            assign partial_flat[gi*4 +: 4] = nib_reg;
        end
    endgenerate

    logic              ovf_next;
    logic [DATA_W-1:0] final_result;

    assign ovf_next = msb_carry_reg ^ carry_reg;

`ifdef SATURATE_EN
    // Overflow direction follows the sign of A: both addends share it when overflow occurs
    always_comb begin
        final_result = partial_flat;
        if (ovf_next) begin
            final_result = a_reg[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                           : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign final_result = partial_flat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_reg      <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            negative_reg  <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                result_reg    <= final_result;
                carry_out_reg <= carry_reg;
                overflow_reg  <= ovf_next;
                zero_reg      <= (final_result == '0);
                negative_reg  <= final_result[DATA_W-1];
            end
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.zero      = zero_reg;
    assign bus.negative  = negative_reg;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed and back-to-back random checks of nibble_serial_addsub (NIBBLES=4).
// Build with +define+SATURATE_EN to check the clamping variant.
module tb_nibble_serial_addsub;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   cyc;

    nibble_serial_addsub_if #(.NIBBLES(4)) bus ();

    nibble_serial_addsub #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flags packed as {carry_out, overflow, zero, negative}
    task automatic check_out(input string tag, input logic [15:0] res, input logic [3:0] flags);
        check({tag, "_res"}, {16'h0, bus.result}, {16'h0, res});
        check({tag, "_flags"},
              {28'h0, bus.carry_out, bus.overflow, bus.zero, bus.negative},
              {28'h0, flags});
    endtask

    // Reference: plain 17-bit arithmetic plus the textbook same-sign overflow rule
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] bb;
        logic [16:0] full;
        logic [15:0] r;
        logic        c, v;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'h0, s};
        r    = full[15:0];
        c    = full[16];
        v    = (a[15] == bb[15]) && (r[15] != a[15]);
`ifdef SATURATE_EN
        if (v) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {c, v, (r == 16'h0), r[15], r};
    endfunction

    // Called #1 after a posedge; returns cycles from the accepting edge to done
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("[TB] op %h %s %h -> %h c=%b v=%b z=%b n=%b lat=%0d",
                 a, s ? "-" : "+", b, bus.result, bus.carry_out, bus.overflow,
                 bus.zero, bus.negative, lat);
    endtask

    initial begin
        int          lat;
        int          dones;
        int          last_done;
        logic [15:0] ra, rb;
        logic        rs;
        logic [19:0] exp;

        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check_out("rst", 16'h0000, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: plain add with latency check
        bus.start = 1'b1; bus.op_a = 16'h1234; bus.op_b = 16'h0FFF; bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("t1_busy", {31'h0, bus.busy}, 32'h1);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t1_lat", lat, 5);
        check_out("t1", 16'h2233, 4'b0000);
        @(posedge clk); #1;
        check("t1_done_pulse", {31'h0, bus.done}, 32'h0);
        check_out("t1_hold", 16'h2233, 4'b0000);

        // 2: positive signed overflow
        do_op(16'h7FFF, 16'h0001, 1'b0, lat);
        check("t2_lat", lat, 5);
`ifdef SATURATE_EN
        check_out("t2", 16'h7FFF, 4'b0100);
`else
        check_out("t2", 16'h8000, 4'b0101);
`endif

        // 3b: negative signed overflow on subtract
        do_op(16'h8000, 16'h0001, 1'b1, lat);
`ifdef SATURATE_EN
        check_out("t3b", 16'h8000, 4'b1101);
`else
        check_out("t3b", 16'h7FFF, 4'b1100);
`endif

        // 4: equal subtract, with a start pulse during RUN that must be ignored
        bus.start = 1'b1; bus.op_a = 16'h5A5A; bus.op_b = 16'h5A5A; bus.sub = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        $display("[TB] op 5a5a - 5a5a (start pulsed mid-run) -> %h dones=%0d", bus.result, dones);
        check("t4_dones", dones, 1);
        check("t4_idle", {31'h0, bus.busy}, 32'h0);
        check_out("t4", 16'h0000, 4'b1010);

        // 3a: borrow through all nibbles
        do_op(16'h0000, 16'h0001, 1'b1, lat);
        check_out("t3a", 16'hFFFF, 4'b0001);

        // 5: asynchronous reset in the 2nd RUN cycle
        bus.start = 1'b1; bus.op_a = 16'h1234; bus.op_b = 16'h0FFF; bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset mid-run -> busy=%b result=%h", bus.busy, bus.result);
        check("t5_busy", {31'h0, bus.busy}, 32'h0);
        check("t5_done", {31'h0, bus.done}, 32'h0);
        check_out("t5_rst", 16'h0000, 4'b0000);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        check("t5_no_stale_done", dones, 0);
        do_op(16'h0001, 16'h0001, 1'b0, lat);
        check("t5_lat", lat, 5);
        check_out("t5", 16'h0002, 4'b0000);

        // 6: back-to-back with start held high, 1000 random ops
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
        bus.start = 1'b1; bus.op_a = ra; bus.op_b = rb; bus.sub = rs;
        @(posedge clk); #1;
        last_done = -1;
        for (int n = 0; n < 1000; n++) begin
            exp = model(ra, rb, rs);
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            bus.op_a = ra; bus.op_b = rb; bus.sub = rs;
            lat = 0;
            while (!bus.done && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("[TB] b2b %0d -> %h c=%b v=%b z=%b n=%b lat=%0d", n, bus.result,
                     bus.carry_out, bus.overflow, bus.zero, bus.negative, lat);
            check_out("b2b", exp[15:0], exp[19:16]);
            if (last_done >= 0) check("b2b_spacing", cyc - last_done, 6);
            else                check("b2b_lat", lat, 5);
            last_done = cyc;
            if (lat >= 20) break;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
